// File: rtl/im_fetch_sequencer_pkg.sv
// rtl/im_fetch_sequencer_pkg.sv - shared types and defaults for the instruction-memory fetch sequencer
package im_fetch_sequencer_pkg;

    localparam int DEF_INSTRUCTION_SIZE = 32;
    localparam int DEF_ADDR_SIZE_IM     = 7;
    localparam int OPCODE_WIDTH         = 4;
    localparam logic [OPCODE_WIDTH-1:0] DEF_HALT_OPCODE = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/im_fetch_sequencer.sv
// rtl/im_fetch_sequencer.sv - walks instruction memory from a start PC and hands words to the decoder
module im_fetch_sequencer
    import im_fetch_sequencer_pkg::*;
#(
    parameter int INSTRUCTION_SIZE = DEF_INSTRUCTION_SIZE,
    parameter int ADDR_SIZE_IM     = DEF_ADDR_SIZE_IM,
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable_PC_IM,
    input  logic [ADDR_SIZE_IM-1:0]     start_PC_IM_address,
    input  logic                        im_empty,
    output logic                        im_rd_en,
    output logic [ADDR_SIZE_IM-1:0]     im_rd_addr,
    input  logic [INSTRUCTION_SIZE-1:0] im_rd_data,
    output logic                        instr_valid,
    input  logic                        instr_ready,
    output logic [INSTRUCTION_SIZE-1:0] instr_data,
    output logic [ADDR_SIZE_IM-1:0]     instr_pc,
    output logic                        pc_busy,
    output logic                        pc_done,
    output logic                        pc_overflow
);

    localparam logic [ADDR_SIZE_IM-1:0] PC_LAST = {ADDR_SIZE_IM{1'b1}};
    localparam logic [ADDR_SIZE_IM-1:0] PC_ONE  = ADDR_SIZE_IM'(1);

    state_t                        state, state_n;
    logic [ADDR_SIZE_IM-1:0]       pc, pc_n;
    logic                          enable_q;
    logic                          armed;
    logic                          data_phase;
    logic                          start;
    logic                          rd_en_n;
    logic [ADDR_SIZE_IM-1:0]       rd_addr_n;
    logic                          valid_n;
    logic [INSTRUCTION_SIZE-1:0]   data_n;
    logic [ADDR_SIZE_IM-1:0]       ipc_n;
    logic                          done_n;
    logic                          ovf_n;
    logic                          busy_n;
    logic [OPCODE_WIDTH-1:0]       opcode;

    // armed stays low after reset until enable is seen low, so a level held through reset is not a start
    assign start  = enable_PC_IM & ~enable_q & armed;
    assign opcode = instr_data[INSTRUCTION_SIZE-1 -: OPCODE_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            pc          <= '0;
            enable_q    <= 1'b0;
            armed       <= 1'b0;
            data_phase  <= 1'b0;
            im_rd_en    <= 1'b0;
            im_rd_addr  <= '0;
            instr_valid <= 1'b0;
            instr_data  <= '0;
            instr_pc    <= '0;
            pc_busy     <= 1'b0;
            pc_done     <= 1'b0;
            pc_overflow <= 1'b0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            enable_q    <= enable_PC_IM;
            armed       <= armed | ~enable_PC_IM;
            data_phase  <= im_rd_en;
            im_rd_en    <= rd_en_n;
            im_rd_addr  <= rd_addr_n;
            instr_valid <= valid_n;
            instr_data  <= data_n;
            instr_pc    <= ipc_n;
            pc_busy     <= busy_n;
            pc_done     <= done_n;
            pc_overflow <= ovf_n;
        end
    end

    always_comb begin
        state_n   = state;
        pc_n      = pc;
        rd_en_n   = 1'b0;
        rd_addr_n = im_rd_addr;
        valid_n   = instr_valid;
        data_n    = instr_data;
        ipc_n     = instr_pc;
        done_n    = pc_done;
        ovf_n     = pc_overflow;
        case (state)
            ST_IDLE: begin
                valid_n = 1'b0;
                if (start) begin
                    pc_n    = start_PC_IM_address;
                    state_n = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (!enable_PC_IM) begin
                    state_n = ST_IDLE;
                end else if (!im_empty) begin
                    rd_en_n   = 1'b1;
                    rd_addr_n = pc;
                    state_n   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // read data is present in the cycle after the strobe cycle
                if (!enable_PC_IM) begin
                    state_n = ST_IDLE;
                end else if (data_phase) begin
                    data_n  = im_rd_data;
                    ipc_n   = pc;
                    valid_n = 1'b1;
                    state_n = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!enable_PC_IM) begin
                    valid_n = 1'b0;
                    state_n = ST_IDLE;
                end else if (instr_ready) begin
                    valid_n = 1'b0;
                    if (opcode == HALT_OPCODE) begin
                        done_n  = 1'b1;
                        state_n = ST_DONE;
                    end else if (pc == PC_LAST) begin
                        done_n  = 1'b1;
                        ovf_n   = 1'b1;
                        state_n = ST_DONE;
                    end else begin
                        pc_n = pc + PC_ONE;
                        // issue the next read on the accept edge to keep one instruction every three cycles
                        if (!im_empty) begin
                            rd_en_n   = 1'b1;
                            rd_addr_n = pc + PC_ONE;
                            state_n   = ST_WAIT;
                        end else begin
                            state_n = ST_FETCH;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (!enable_PC_IM) begin
                    done_n  = 1'b0;
                    ovf_n   = 1'b0;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                valid_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
        busy_n = (state_n != ST_IDLE) && (state_n != ST_DONE);
    end

endmodule

// File: tb/tb_im_fetch_sequencer.sv
// tb/tb_im_fetch_sequencer.sv - directed self-checking bench for im_fetch_sequencer
module tb_im_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable_PC_IM;
    logic [6:0]  start_PC_IM_address;
    logic        im_empty;
    logic        im_rd_en;
    logic [6:0]  im_rd_addr;
    logic [31:0] im_rd_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic [6:0]  instr_pc;
    logic        pc_busy;
    logic        pc_done;
    logic        pc_overflow;

    logic [31:0] mem [0:127];
    int tests = 0;
    int fails = 0;
    int ninstr;

    im_fetch_sequencer dut (
        .clk                 (clk),
        .rst                 (rst),
        .enable_PC_IM        (enable_PC_IM),
        .start_PC_IM_address (start_PC_IM_address),
        .im_empty            (im_empty),
        .im_rd_en            (im_rd_en),
        .im_rd_addr          (im_rd_addr),
        .im_rd_data          (im_rd_data),
        .instr_valid         (instr_valid),
        .instr_ready         (instr_ready),
        .instr_data          (instr_data),
        .instr_pc            (instr_pc),
        .pc_busy             (pc_busy),
        .pc_done             (pc_done),
        .pc_overflow         (pc_overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_rd_en) im_rd_data <= mem[im_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_valid(input string tag, input int max);
        int n;
        n = 0;
        while (instr_valid !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk(tag, {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 32'hA000_0000 | i;
        mem[2]   = 32'h1000_0051;
        mem[3]   = 32'h2000_0015;
        mem[4]   = 32'hF000_0000;
        mem[5]   = 32'hF000_0005;
        mem[7]   = 32'hF000_0007;
        mem[126] = 32'h1234_5678;
        mem[127] = 32'h0ABC_DEF0;
        im_rd_data = '0;
        rst = 1'b1;
        enable_PC_IM = 1'b0;
        start_PC_IM_address = '0;
        im_empty = 1'b0;
        instr_ready = 1'b1;
        tick(); tick();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_rd_en", {31'd0, im_rd_en}, 32'd0);
        chk("rst_busy", {31'd0, pc_busy}, 32'd0);
        chk("rst_done", {31'd0, pc_done}, 32'd0);
        rst = 1'b0;
        tick(); tick();

        // basic run: 2,3,4 with HALT at 4
        start_PC_IM_address = 7'd2;
        enable_PC_IM = 1'b1;
        tick();
        chk("basic_busy", {31'd0, pc_busy}, 32'd1);
        chk("basic_no_strobe_yet", {31'd0, im_rd_en}, 32'd0);
        tick();
        chk("basic_rd_en_n1", {31'd0, im_rd_en}, 32'd1);
        chk("basic_rd_addr_n1", {25'd0, im_rd_addr}, 32'd2);
        tick();
        chk("basic_rd_en_n2", {31'd0, im_rd_en}, 32'd0);
        chk("basic_valid_n2", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("basic_valid_n3", {31'd0, instr_valid}, 32'd1);
        chk("basic_data0", instr_data, 32'h1000_0051);
        chk("basic_pc0", {25'd0, instr_pc}, 32'd2);
        tick();
        chk("basic_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("basic_rd_addr1", {25'd0, im_rd_addr}, 32'd3);
        chk("basic_rd_en1", {31'd0, im_rd_en}, 32'd1);
        tick(); tick();
        chk("basic_valid1", {31'd0, instr_valid}, 32'd1);
        chk("basic_data1", instr_data, 32'h2000_0015);
        chk("basic_pc1", {25'd0, instr_pc}, 32'd3);
        tick(); tick(); tick();
        chk("basic_valid2", {31'd0, instr_valid}, 32'd1);
        chk("basic_data2", instr_data, 32'hF000_0000);
        chk("basic_pc2", {25'd0, instr_pc}, 32'd4);
        tick();
        chk("basic_done", {31'd0, pc_done}, 32'd1);
        chk("basic_ovf", {31'd0, pc_overflow}, 32'd0);
        chk("basic_busy_done", {31'd0, pc_busy}, 32'd0);
        chk("basic_valid_done", {31'd0, instr_valid}, 32'd0);
        enable_PC_IM = 1'b0;
        tick();
        chk("basic_done_clear", {31'd0, pc_done}, 32'd0);

        // backpressure on mem[2], then abort in HOLD at pc 3, then restart at 5
        instr_ready = 1'b0;
        enable_PC_IM = 1'b1;
        wait_valid("bp_valid_timeout", 10);
        for (int i = 0; i < 6; i++) begin
            chk("bp_valid_stable", {31'd0, instr_valid}, 32'd1);
            chk("bp_data_stable", instr_data, 32'h1000_0051);
            chk("bp_pc_stable", {25'd0, instr_pc}, 32'd2);
            chk("bp_no_strobe", {31'd0, im_rd_en}, 32'd0);
            tick();
        end
        instr_ready = 1'b1;
        tick();
        chk("bp_accept_drop", {31'd0, instr_valid}, 32'd0);
        chk("bp_accept_strobe", {31'd0, im_rd_en}, 32'd1);
        chk("bp_accept_addr", {25'd0, im_rd_addr}, 32'd3);
        instr_ready = 1'b0;
        wait_valid("abort_valid_timeout", 10);
        chk("abort_pc3", {25'd0, instr_pc}, 32'd3);
        enable_PC_IM = 1'b0;
        tick();
        chk("abort_valid_drop", {31'd0, instr_valid}, 32'd0);
        chk("abort_idle", {31'd0, pc_busy}, 32'd0);
        chk("abort_not_done", {31'd0, pc_done}, 32'd0);
        start_PC_IM_address = 7'd5;
        enable_PC_IM = 1'b1;
        instr_ready = 1'b1;
        wait_valid("restart_valid_timeout", 10);
        chk("restart_pc5", {25'd0, instr_pc}, 32'd5);
        chk("restart_data5", instr_data, 32'hF000_0005);
        tick();
        chk("restart_done", {31'd0, pc_done}, 32'd1);
        enable_PC_IM = 1'b0;
        tick();

        // empty stall
        im_empty = 1'b1;
        start_PC_IM_address = 7'd7;
        enable_PC_IM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("empty_no_strobe", {31'd0, im_rd_en}, 32'd0);
            chk("empty_busy", {31'd0, pc_busy}, 32'd1);
        end
        im_empty = 1'b0;
        tick();
        chk("empty_release_strobe", {31'd0, im_rd_en}, 32'd1);
        chk("empty_release_addr", {25'd0, im_rd_addr}, 32'd7);
        wait_valid("empty_valid_timeout", 10);
        chk("empty_data", instr_data, 32'hF000_0007);
        enable_PC_IM = 1'b0;
        tick();

        // end of memory: 126, 127, no HALT
        start_PC_IM_address = 7'd126;
        enable_PC_IM = 1'b1;
        ninstr = 0;
        for (int i = 0; i < 30 && pc_done !== 1'b1; i++) begin
            tick();
            if (im_rd_en) chk("eom_addr_nonzero", {31'd0, im_rd_addr != 7'd0}, 32'd1);
            if (instr_valid) ninstr++;
        end
        chk("eom_count", ninstr, 32'd2);
        chk("eom_done", {31'd0, pc_done}, 32'd1);
        chk("eom_ovf", {31'd0, pc_overflow}, 32'd1);
        chk("eom_last_pc", {25'd0, instr_pc}, 32'd127);
        enable_PC_IM = 1'b0;
        tick();
        chk("eom_ovf_clear", {31'd0, pc_overflow}, 32'd0);

        // reset while holding an instruction
        instr_ready = 1'b0;
        start_PC_IM_address = 7'd2;
        enable_PC_IM = 1'b1;
        wait_valid("rstmid_valid_timeout", 10);
        rst = 1'b1;
        #1;
        chk("rstmid_valid", {31'd0, instr_valid}, 32'd0);
        chk("rstmid_data", instr_data, 32'd0);
        chk("rstmid_pc", {25'd0, instr_pc}, 32'd0);
        chk("rstmid_busy", {31'd0, pc_busy}, 32'd0);
        chk("rstmid_addr", {25'd0, im_rd_addr}, 32'd0);
        tick();
        rst = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rstmid_no_fetch", {31'd0, im_rd_en}, 32'd0);
            chk("rstmid_stay_idle", {31'd0, pc_busy}, 32'd0);
        end
        enable_PC_IM = 1'b0;
        tick();
        enable_PC_IM = 1'b1;
        tick();
        chk("rstmid_new_edge_busy", {31'd0, pc_busy}, 32'd1);
        wait_valid("rstmid_refetch_timeout", 10);
        chk("rstmid_refetch_pc", {25'd0, instr_pc}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
